dm_cache_controller: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller. Sits between the single-cycle datapath's data port and the backing word-addressed main memory. Takes the ALU result address, store data and load/store strobes. Returns load data and freezes the datapath with a stall while it fills a line or completes a memory write.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_line_array.sv | 60 ++++++
 rtl/dm_cache_controller.sv | 184 ++++++++++++++++++
 tb/tb_dm_cache_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
// Module : cache_pkg
// Shared geometry, state encoding and address-field helpers for the cache.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int DEF_ADDR_W         = 10;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_LINES          = 32;
    localparam int DEF_WORDS_PER_LINE = 4;

    localparam int OFFSET_W = $clog2(DEF_WORDS_PER_LINE);
    localparam int INDEX_W  = $clog2(DEF_LINES);
    localparam int TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [DEF_ADDR_W-1:0] a);
        return a[DEF_ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [DEF_ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [DEF_ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_line_array.sv
// ============================================================================
// Module : cache_line_array
// Valid/tag/data storage with a combinational read port and one write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_line_array #(
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_BITS    = 3,
    parameter int DATA_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [DATA_W-1:0]      rd_word,
    input  logic                   wr_en,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   tag_set,
    input  logic [TAG_BITS-1:0]    wr_tag
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << (INDEX_BITS + OFFSET_BITS);

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_word  = data_q[{rd_index, rd_offset}];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en && tag_set) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
            if (tag_set) begin
                tag_q[wr_index] <= wr_tag;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dm_cache_controller.sv
// ============================================================================
// Module : dm_cache_controller
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dm_cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_data,
    input  logic              write_data,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              stall,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS;

    state_t state, state_next;

    logic [OFF_BITS-1:0]          fill_cnt;
    logic [TAG_BITS+IDX_BITS-1:0] blk_addr;

    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_BITS-1:0] req_idx;
    logic [OFF_BITS-1:0] req_off;
    logic                line_valid;
    logic [TAG_BITS-1:0] line_tag;
    logic [DATA_W-1:0]   line_word;
    logic                hit;
    logic                last_word;

    logic                arr_we;
    logic                arr_tag_set;
    logic [IDX_BITS-1:0] arr_idx;
    logic [OFF_BITS-1:0] arr_off;
    logic [DATA_W-1:0]   arr_wdata;

    assign req_tag   = address[ADDR_W-1 -: TAG_BITS];
    assign req_idx   = address[OFF_BITS +: IDX_BITS];
    assign req_off   = address[OFF_BITS-1:0];
    assign hit       = line_valid && (line_tag == req_tag);
    assign last_word = (fill_cnt == OFF_BITS'(WORDS_PER_LINE - 1));

    cache_line_array #(
        .INDEX_BITS  (IDX_BITS),
        .OFFSET_BITS (OFF_BITS),
        .TAG_BITS    (TAG_BITS),
        .DATA_W      (DATA_W)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (req_idx),
        .rd_offset (req_off),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_word   (line_word),
        .wr_en     (arr_we),
        .wr_index  (arr_idx),
        .wr_offset (arr_off),
        .wr_data   (arr_wdata),
        .tag_set   (arr_tag_set),
        .wr_tag    (blk_addr[IDX_BITS +: TAG_BITS])
    );

    // Single write port shared by line fill and store-hit update.
    always_comb begin
        arr_we      = 1'b0;
        arr_tag_set = 1'b0;
        arr_idx     = req_idx;
        arr_off     = req_off;
        arr_wdata   = data_in;
        if (state == S_FILL && mem_ready) begin
            arr_we      = 1'b1;
            arr_tag_set = last_word;
            arr_idx     = blk_addr[IDX_BITS-1:0];
            arr_off     = fill_cnt;
            arr_wdata   = mem_rdata;
        end else if (state == S_WRITE && mem_ready && hit) begin
            arr_we = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
            blk_addr <= '0;
        end else if (state == S_IDLE && read_data && !write_data && !hit) begin
            fill_cnt <= '0;
            blk_addr <= address[ADDR_W-1:OFF_BITS];
        end else if (state == S_FILL && mem_ready) begin
            fill_cnt <= fill_cnt + OFF_BITS'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (write_data) begin
                    state_next = S_WRITE;
                end else if (read_data && !hit) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ready && last_word) begin
                    state_next = S_IDLE;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are forced low for the whole time rst is asserted.
    always_comb begin
        stall      = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        data_out   = '0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (write_data) begin
                        stall = 1'b1;
                    end else if (read_data) begin
                        if (hit) begin
                            data_out = line_word;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    stall      = 1'b1;
                    mem_rd_req = 1'b1;
                    mem_addr   = {blk_addr, fill_cnt};
                end
                S_WRITE: begin
                    mem_wr_req = 1'b1;
                    mem_addr   = address;
                    mem_wdata  = data_in;
                    stall      = !mem_ready;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_cache_controller.sv
// ============================================================================
// Module : tb_dm_cache_controller
// Directed self-checking bench for dm_cache_controller with a memory model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dm_cache_controller;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_data;
    logic        write_data;
    logic [9:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        stall;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    // Untouched memory word k reads as 0x1000+k; stores override it.
    bit [31:0] mem_store   [1024];
    bit        mem_written [1024];

    assign mem_rdata = mem_written[mem_addr] ? mem_store[mem_addr]
                                             : (32'h1000 + 32'(mem_addr));

    always @(posedge clk) begin
        if (mem_wr_req && mem_ready) begin
            mem_store[mem_addr]   <= mem_wdata;
            mem_written[mem_addr] <= 1'b1;
        end
    end

    always #5 clk = ~clk;

    dm_cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .read_data  (read_data),
        .write_data (write_data),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .stall      (stall),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Caller has just presented a missing read of a; checks the miss cycle,
    // the four fill beats and the hit that follows.
    task automatic fill_line(input logic [9:0] a, input logic [31:0] exp_word);
        #1;
        chk("miss_stall", 32'(stall), 32'd1);
        chk("miss_no_rd", 32'(mem_rd_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk("fill_stall", 32'(stall), 32'd1);
            chk("fill_rd_req", 32'(mem_rd_req), 32'd1);
            chk("fill_no_wr", 32'(mem_wr_req), 32'd0);
            chk("fill_addr", 32'(mem_addr),
                32'({addr_tag(a), addr_index(a), OFFSET_W'(k)}));
        end
        tick();
        #1;
        chk("fill_done_stall", 32'(stall), 32'd0);
        chk("fill_done_rd", 32'(mem_rd_req), 32'd0);
        chk("fill_done_data", data_out, exp_word);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        read_data  = 1'b1;
        write_data = 1'b0;
        address    = 10'h004;
        data_in    = '0;
        mem_ready  = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rd_req", 32'(mem_rd_req), 32'd0);
        chk("rst_data", data_out, 32'd0);
        repeat (2) @(posedge clk);
        #2;

        // 1: cold miss on 0x004
        rst       = 1'b0;
        mem_ready = 1'b1;
        fill_line(10'h004, 32'h0000_1004);

        // 2: same-line hit
        tick();
        address = 10'h006;
        #1;
        chk("hit_stall", 32'(stall), 32'd0);
        chk("hit_data", data_out, 32'h0000_1006);
        chk("hit_no_rd", 32'(mem_rd_req), 32'd0);

        // 3: store hit with three-cycle memory write
        tick();
        read_data  = 1'b0;
        write_data = 1'b1;
        address    = 10'h005;
        data_in    = 32'hDEAD_BEEF;
        mem_ready  = 1'b0;
        #1;
        chk("wr_idle_stall", 32'(stall), 32'd1);
        chk("wr_idle_no_req", 32'(mem_wr_req), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) mem_ready = 1'b1;
            #1;
            chk("wr_req", 32'(mem_wr_req), 32'd1);
            chk("wr_no_rd", 32'(mem_rd_req), 32'd0);
            chk("wr_addr", 32'(mem_addr), 32'h005);
            chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("wr_stall", 32'(stall), (c == 2) ? 32'd0 : 32'd1);
        end
        tick();
        write_data = 1'b0;
        read_data  = 1'b1;
        mem_ready  = 1'b0;
        #1;
        chk("wr_hit_stall", 32'(stall), 32'd0);
        chk("wr_hit_data", data_out, 32'hDEAD_BEEF);
        chk("wr_mem_word", mem_store[5], 32'hDEAD_BEEF);

        // 4: store miss goes to memory only, then read allocates
        tick();
        read_data  = 1'b0;
        write_data = 1'b1;
        address    = 10'h100;
        data_in    = 32'hCAFE_F00D;
        mem_ready  = 1'b1;
        #1;
        chk("wmiss_idle_stall", 32'(stall), 32'd1);
        tick();
        #1;
        chk("wmiss_req", 32'(mem_wr_req), 32'd1);
        chk("wmiss_addr", 32'(mem_addr), 32'h100);
        chk("wmiss_stall", 32'(stall), 32'd0);
        tick();
        write_data = 1'b0;
        read_data  = 1'b1;
        fill_line(10'h100, 32'hCAFE_F00D);

        // 5: conflict on index 1 evicts line 0x004
        tick();
        address = 10'h004;
        #1;
        chk("pre_evict_stall", 32'(stall), 32'd0);
        chk("pre_evict_data", data_out, 32'h0000_1004);
        tick();
        address = 10'h084;
        fill_line(10'h084, 32'h0000_1084);
        tick();
        address = 10'h004;
        fill_line(10'h004, 32'h0000_1004);
        tick();
        address = 10'h005;
        #1;
        chk("refill_w5_stall", 32'(stall), 32'd0);
        chk("refill_w5_data", data_out, 32'hDEAD_BEEF);

        // 6: reset in the middle of a fill
        tick();
        address = 10'h084;
        fill_line(10'h084, 32'h0000_1084);
        tick();
        address = 10'h004;
        #1;
        chk("mid_miss_stall", 32'(stall), 32'd1);
        tick();
        #1;
        chk("mid_beat0", 32'(mem_addr), 32'h004);
        tick();
        #1;
        chk("mid_beat1", 32'(mem_addr), 32'h005);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_rd_req", 32'(mem_rd_req), 32'd0);
        chk("mid_rst_data", data_out, 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        tick();
        rst = 1'b0;
        fill_line(10'h004, 32'h0000_1004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
